mo_line_buffer: RTL and testbench
=================================

# mo_line_buffer

Double-buffered motion-object line buffer pair: the consumer end of the horizontal address counters that produce `addr1`/`addr2`. Each scanline, one buffer is the write bank and receives sprite pixels. The other is the read bank: it is scanned out to the video mixer and erased behind the beam. Banks swap at every line start, and a reset-time sweep zeroes both RAMs.

## Interface
Parameters:
- `PIXW`, 4: pixel/colour-index width; value 0 = transparent.
- `AW`, 8: address width, one entry per horizontal position (256 entries per buffer).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce5`  in  1  pixel clock enable; all functional updates are qualified by it.
- `line_start`  in  1  bank-swap request, sampled on `ce5` ticks.
- `addr1`  in  AW  address for buffer 1, from the horizontal counter.
- `addr2`  in  AW  address for buffer 2, from the horizontal counter.
- `wr_pix`  in  PIXW  sprite pixel for the write bank.
- `wr_en`  in  1  sprite pixel valid, sampled on `ce5` ticks.
- `pix_out`  out  PIXW  registered pixel from the read bank.
- `bank`  out  1  0 = buffer 1 is write / buffer 2 is read; 1 = swapped.
- `busy`  out  1  high during the clear sweep.

## Operation
- **Storage:** two independent 2^AW x PIXW RAMs. Buffer 1 is always addressed by `addr1` and buffer 2 by `addr2`, in both roles.
- **States:** `CLEAR` and `RUN`. Reset enters `CLEAR`.
- **CLEAR state:**
  - Runs at full `clk` rate, ignoring `ce5`.
  - An internal AW-bit sweep counter starts at 0 and writes 0 to the same address in both RAMs on every `clk`.
  - After address 2^AW-1 is written, the block enters `RUN`.
  - During `CLEAR`: `wr_en` and `line_start` are ignored, `pix_out` is held at 0, `busy` = 1.
- **RUN state:** `busy` = 0. Each `ce5` tick does the following, all on the current (pre-swap) `bank`:
  - *Write bank:* if `wr_en` and `wr_pix` != 0, write `wr_pix` at the write-bank address. A zero pixel never writes, so the underlying pixel is kept. A later nonzero write to the same address overwrites an earlier one.
  - *Read bank:* read-first at the read-bank address. `pix_out` is loaded with the old contents and 0 is written back to that entry (erase-behind).
  - *Swap:* if `line_start` is high, `bank` toggles. The new mapping applies from the next `ce5` tick.
- **Bank isolation:** read/erase and write always target different RAMs, so no intra-RAM conflict exists.
- **Held `ce5`:** with `ce5` low, no RAM write occurs and `bank`, `pix_out` and the state register all hold.

## Timing
- **Reset values:**
  - `pix_out` = 0, `bank` = 0, `busy` = 1, sweep counter = 0, state = `CLEAR`.
  - RAM contents are not reset directly; the sweep clears them.
- **Sweep length:** `busy` is high for exactly 2^AW `clk` cycles after `reset` deasserts (256 clocks at AW = 8). It drops on the clock edge that writes address 255.
- **Read latency:** one `ce5` tick. The address presented on tick N appears on `pix_out` after tick N's edge, and the entry reads 0 from tick N+1 onward.
- **Write latency:** a pixel written on tick N is readable once its buffer becomes the read bank, i.e. after the next `line_start` tick.
- **`line_start` with `wr_en` on the same tick:** the write goes to the old write bank.
- **`line_start` on consecutive ticks:** `bank` toggles on each tick.
- **Reset mid-operation:** all registers return to reset values immediately. Any in-progress sweep or line is abandoned and the sweep restarts at 0 after deassertion.
- **Address wrap:** addresses are used modulo 2^AW. Entry 255 is followed by entry 0 with no special handling.

## Test plan
- **Reset sweep:** assert `reset` for 3 clocks, then release with `ce5` = 0.
  - `busy` = 1 for exactly 256 clocks, then 0.
  - `pix_out` = 0 and `bank` = 0 throughout.
  - After the sweep, reading every address of both banks returns 0.
- **Basic write/read/erase:**
  - Setup: `bank` = 0, `addr1` = 0x10, `wr_pix` = 5, `wr_en` = 1 for one `ce5` tick; then pulse `line_start`.
  - Present `addr1` = 0x10: `pix_out` = 5 one tick later.
  - After two further swaps, the same read returns 0 (erased).
- **Transparency/priority** at `addr1` = 0x20:
  - Write 7 then 0: read gives 7.
  - Write 7 then 3: read gives 3.
- **Simultaneous swap and write:**
  - Setup: `line_start` = 1, `wr_en` = 1, `wr_pix` = 9 on the same tick with `bank` = 0 and `addr1` = 0x30.
  - Required: 9 lands in buffer 1; `bank` = 1 after the tick.
  - Next line: reading `addr1` = 0x30 gives 9.
- **Clock-enable gating:** hold `ce5` = 0 for 10 clocks while toggling `wr_en`, `line_start` and the addresses. `bank`, `pix_out` and the RAM contents are unchanged.
- **Reset mid-line:** assert `reset` while `bank` = 1 and `pix_out` = 6.
  - Immediately: `pix_out` = 0, `bank` = 0, `busy` = 1.
  - The sweep completes in 256 clocks, and previously written data reads back 0.

Source files
------------

// File: rtl/mo_line_buffer.sv
// Double-buffered motion-object line buffer: one RAM takes sprite pixels while the
// other is scanned out and erased behind the beam; banks swap on line_start.
module mo_line_buffer #(
    parameter int PIXW = 4,
    parameter int AW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce5,
    input  logic            line_start,
    input  logic [AW-1:0]   addr1,
    input  logic [AW-1:0]   addr2,
    input  logic [PIXW-1:0] wr_pix,
    input  logic            wr_en,
    output logic [PIXW-1:0] pix_out,
    output logic            bank,
    output logic            busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   sweep, sweep_next;
    logic            bank_next;
    logic [PIXW-1:0] pix_next;

    logic [PIXW-1:0] ram1 [DEPTH];
    logic [PIXW-1:0] ram2 [DEPTH];

    logic            we1, we2;
    logic [AW-1:0]   wa1, wa2;
    logic [PIXW-1:0] wd1, wd2;
    logic            pix_wr;

    // Transparent pixels never write, so whatever is underneath survives.
    assign pix_wr = wr_en && (wr_pix != '0);
    assign busy   = (state == ST_CLEAR);

    always_comb begin
        state_next = state;
        sweep_next = sweep;
        bank_next  = bank;
        pix_next   = pix_out;
        we1        = 1'b0;
        we2        = 1'b0;
        wa1        = addr1;
        wa2        = addr2;
        wd1        = '0;
        wd2        = '0;
        case (state)
            ST_CLEAR: begin
                we1        = 1'b1;
                we2        = 1'b1;
                wa1        = sweep;
                wa2        = sweep;
                sweep_next = sweep + AW'(1);
                if (sweep == {AW{1'b1}}) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (ce5) begin
                    // Read bank is read-first and erased; write bank takes the sprite pixel.
                    if (!bank) begin
                        pix_next = ram2[addr2];
                        we2      = 1'b1;
                        we1      = pix_wr;
                        wd1      = wr_pix;
                    end else begin
                        pix_next = ram1[addr1];
                        we1      = 1'b1;
                        we2      = pix_wr;
                        wd2      = wr_pix;
                    end
                    if (line_start) bank_next = ~bank;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_CLEAR;
            sweep   <= '0;
            bank    <= 1'b0;
            pix_out <= '0;
        end else begin
            state   <= state_next;
            sweep   <= sweep_next;
            bank    <= bank_next;
            pix_out <= pix_next;
        end
    end

    always_ff @(posedge clk) begin
        if (we1) ram1[wa1] <= wd1;
        if (we2) ram2[wa2] <= wd2;
    end

endmodule

// File: tb/tb_mo_line_buffer.sv
// Bench for mo_line_buffer: directed scenarios plus random traffic against an
// array-based model of the two line buffers.
module tb_mo_line_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce5 = 1'b0;
    logic       line_start = 1'b0;
    logic [7:0] addr1 = '0;
    logic [7:0] addr2 = '0;
    logic [3:0] wr_pix = '0;
    logic       wr_en = 1'b0;
    logic [3:0] pix_out;
    logic       bank;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] mem [2][256];
    bit         mbank;
    logic [3:0] mpix;

    mo_line_buffer #(.PIXW(4), .AW(8)) dut (
        .clk(clk), .reset(reset), .ce5(ce5), .line_start(line_start),
        .addr1(addr1), .addr2(addr2), .wr_pix(wr_pix), .wr_en(wr_en),
        .pix_out(pix_out), .bank(bank), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) mem[b][i] = '0;
        mbank = 1'b0;
        mpix  = '0;
    endtask

    // One pixel slot; index 0 = buffer 1 (addr1), index 1 = buffer 2 (addr2).
    task automatic tick(input bit ce, input bit ls, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [3:0] px, input bit we);
        int wb, rb;
        logic [7:0] ad [2];
        ce5 = ce; line_start = ls; addr1 = a1; addr2 = a2; wr_pix = px; wr_en = we;
        @(posedge clk); #1;
        if (ce) begin
            ad[0] = a1; ad[1] = a2;
            wb = int'(mbank);
            rb = 1 - wb;
            mpix = mem[rb][ad[rb]];
            mem[rb][ad[rb]] = '0;
            if (we && px != 4'd0) mem[wb][ad[wb]] = px;
            if (ls) mbank = !mbank;
        end
        chk("pix_out", 32'(pix_out), 32'(mpix));
        chk("bank", 32'(bank), 32'(mbank));
        chk("busy_run", 32'(busy), 32'd0);
    endtask

    task automatic sweep_check(input string tag);
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk); #1;
            chk({tag, "_busy"}, 32'(busy), (k < 256) ? 32'd1 : 32'd0);
            chk({tag, "_pix"}, 32'(pix_out), 32'd0);
            chk({tag, "_bank"}, 32'(bank), 32'd0);
        end
    endtask

    task automatic do_reset(input string tag);
        ce5 = 1'b0; line_start = 1'b0; wr_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        sweep_check(tag);
    endtask

    // Reads every entry of buffer 2, swaps, reads every entry of buffer 1, swaps back.
    task automatic read_all();
        for (int i = 0; i < 256; i++) tick(1, 0, 8'(i), 8'(i), 4'd0, 0);
        tick(1, 1, 8'd0, 8'd0, 4'd0, 0);
        for (int i = 0; i < 256; i++) tick(1, 0, 8'(i), 8'(i), 4'd0, 0);
        tick(1, 1, 8'd0, 8'd0, 4'd0, 0);
    endtask

    initial begin
        model_reset();
        do_reset("sweep");
        read_all();

        // basic write/read/erase (bank 0)
        tick(1, 0, 8'h10, 8'h00, 4'd5, 1);
        tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 0, 8'h10, 8'h00, 4'd0, 0);
        chk("basic_read", 32'(pix_out), 32'd5);
        tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 0, 8'h10, 8'h00, 4'd0, 0);
        chk("basic_erased", 32'(pix_out), 32'd0);

        // transparency / priority (bank back to 0 first)
        tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 0, 8'h20, 8'h00, 4'd7, 1);
        tick(1, 0, 8'h20, 8'h00, 4'd0, 1);
        tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 0, 8'h20, 8'h00, 4'd0, 0);
        chk("transparent", 32'(pix_out), 32'd7);
        tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 0, 8'h20, 8'h00, 4'd7, 1);
        tick(1, 0, 8'h20, 8'h00, 4'd3, 1);
        tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 0, 8'h20, 8'h00, 4'd0, 0);
        chk("overwrite", 32'(pix_out), 32'd3);

        // simultaneous swap and write
        tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 1, 8'h30, 8'h00, 4'd9, 1);
        chk("simul_bank", 32'(bank), 32'd1);
        tick(1, 0, 8'h30, 8'h00, 4'd0, 0);
        chk("simul_read", 32'(pix_out), 32'd9);

        // clock-enable gating
        repeat (10) tick(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                         4'($urandom), 1'($urandom_range(0, 1)));

        // random traffic
        repeat (400) tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                          8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        // reset mid-line with bank = 1 and pix_out = 6
        if (mbank) tick(1, 1, 8'h00, 8'h00, 4'd0, 0);
        tick(1, 1, 8'h40, 8'h00, 4'd6, 1);
        tick(1, 0, 8'h40, 8'h50, 4'hB, 1);
        chk("mid_pix", 32'(pix_out), 32'd6);
        chk("mid_bank", 32'(bank), 32'd1);
        ce5 = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_pix", 32'(pix_out), 32'd0);
        chk("rst_bank", 32'(bank), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        sweep_check("resweep");
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
